// File: rtl/decode_stage.sv
// RiSC-16 decode stage: IF/ID register, field/immediate decode, register-file read addresses
// and an ID/EX register aligned with read data. Load-use stall logic under DECODE_LOAD_USE_STALL_EN.
module decode_stage #(
  parameter int unsigned p_WORD_LEN     = 16,
  parameter int unsigned p_REG_ADDR_LEN = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [p_WORD_LEN-1:0]     i_instr,
  input  logic [p_WORD_LEN-1:0]     i_pc,
  input  logic                      i_valid,
  output logic                      o_fetch_stall,
  input  logic                      i_stall,
  input  logic                      i_flush,
  output logic [p_REG_ADDR_LEN-1:0] o_src1,
  output logic [p_REG_ADDR_LEN-1:0] o_src2,
  output logic                      o_valid,
  output logic [2:0]                o_op,
  output logic [p_REG_ADDR_LEN-1:0] o_tgt,
  output logic                      o_wr_en,
  output logic [p_WORD_LEN-1:0]     o_imm,
  output logic [p_WORD_LEN-1:0]     o_pc,
  output logic [p_REG_ADDR_LEN-1:0] o_src1_q,
  output logic [p_REG_ADDR_LEN-1:0] o_src2_q
);

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpAddi = 3'd1;
  localparam logic [2:0] OpNand = 3'd2;
  localparam logic [2:0] OpLui  = 3'd3;
  localparam logic [2:0] OpSw   = 3'd4;
  localparam logic [2:0] OpLw   = 3'd5;
  localparam logic [2:0] OpBeq  = 3'd6;
  localparam logic [2:0] OpJalr = 3'd7;

  logic [p_WORD_LEN-1:0]     r_instr;
  logic [p_WORD_LEN-1:0]     r_pc;
  logic                      r_valid;

  logic [2:0]                dec_op;
  logic [p_REG_ADDR_LEN-1:0] fld_a, fld_b, fld_c;
  logic [p_REG_ADDR_LEN-1:0] dec_src1, dec_src2, dec_tgt;
  logic                      dec_writes;
  logic                      dec_wr_en;
  logic [p_WORD_LEN-1:0]     dec_imm;
  logic [p_WORD_LEN-1:0]     simm7;
  logic                      hazard;

  assign dec_op = r_instr[15:13];
  assign fld_a  = r_instr[12:10];
  assign fld_b  = r_instr[9:7];
  assign fld_c  = r_instr[2:0];
  assign simm7  = {{(p_WORD_LEN-7){r_instr[6]}}, r_instr[6:0]};

  // Unused sources stay 0 so r0 reads never look like a dependency.
  always_comb begin
    dec_src1   = '0;
    dec_src2   = '0;
    dec_tgt    = '0;
    dec_writes = 1'b0;
    dec_imm    = '0;
    unique case (dec_op)
      OpAdd, OpNand: begin
        dec_src1   = fld_b;
        dec_src2   = fld_c;
        dec_tgt    = fld_a;
        dec_writes = 1'b1;
      end
      OpAddi, OpLw, OpJalr: begin
        dec_src1   = fld_b;
        dec_tgt    = fld_a;
        dec_writes = 1'b1;
        dec_imm    = simm7;
      end
      OpLui: begin
        dec_tgt    = fld_a;
        dec_writes = 1'b1;
        dec_imm    = {r_instr[9:0], 6'b0};
      end
      OpSw: begin
        dec_src1 = fld_b;
        dec_src2 = fld_a;
        dec_imm  = simm7;
      end
      OpBeq: begin
        dec_src1 = fld_a;
        dec_src2 = fld_b;
        dec_imm  = simm7;
      end
      default: ;
    endcase
  end

  assign dec_wr_en = dec_writes && (dec_tgt != '0);

`ifdef DECODE_LOAD_USE_STALL_EN
  // Unused sources are 0 and o_tgt is nonzero, so a plain match covers "used source".
  assign hazard = r_valid && o_valid && (o_op == OpLw) && (o_tgt != '0) &&
                  ((o_tgt == dec_src1) || (o_tgt == dec_src2));
`else
  assign hazard = 1'b0;
`endif

  assign o_fetch_stall = i_stall | hazard;
  assign o_src1        = dec_src1;
  assign o_src2        = dec_src2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr  <= '0;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      o_valid  <= 1'b0;
      o_op     <= '0;
      o_tgt    <= '0;
      o_wr_en  <= 1'b0;
      o_imm    <= '0;
      o_pc     <= '0;
      o_src1_q <= '0;
      o_src2_q <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      o_valid <= 1'b0;
    end else if (!i_stall) begin
      if (hazard) begin
        // IF/ID holds; ID/EX takes a fully cleared bubble.
        o_valid  <= 1'b0;
        o_op     <= '0;
        o_tgt    <= '0;
        o_wr_en  <= 1'b0;
        o_imm    <= '0;
        o_pc     <= '0;
        o_src1_q <= '0;
        o_src2_q <= '0;
      end else begin
        r_instr  <= i_instr;
        r_pc     <= i_pc;
        r_valid  <= i_valid;
        o_valid  <= r_valid;
        o_op     <= dec_op;
        o_tgt    <= dec_tgt;
        o_wr_en  <= dec_wr_en;
        o_imm    <= dec_imm;
        o_pc     <= r_pc;
        o_src1_q <= dec_src1;
        o_src2_q <= dec_src2;
      end
    end
  end

endmodule
